// File: rtl/ebus_dev.sv
// EBUS I/O device slave: decodes CONO/CONI/DATAO/DATAI for DEV_NUM, paces the
// transfer handshake, and exchanges a 36-bit data word with the device side.
// Optional priority-interrupt request logic is enabled by defining EBUS_DEV_PI_EN.
module ebus_dev #(
  parameter logic [6:0]  DEV_NUM    = 7'o040,
  parameter int unsigned XFER_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:35] EBUS,
  input  logic [0:7]  EBUS_DS,
  input  logic [0:2]  ebusFunc,
  input  logic        ebusDemand,
  output logic        ebusXfer,
  output logic        DEVdrivingEBUS,
  output logic [0:35] DEV_EBUS,
  input  logic        devLoad,
  input  logic [0:35] devData,
  output logic        devReady,
  output logic [0:35] devDataOut,
  output logic        devDataStrobe,
  output logic [1:7]  piReq
);

  localparam int unsigned DW = 36;
  localparam int unsigned CW = 4;
  localparam logic [2:0] F_CONO  = 3'd0;
  localparam logic [2:0] F_CONI  = 3'd1;
  localparam logic [2:0] F_DATAO = 3'd2;
  localparam logic [2:0] F_DATAI = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [2:0]      r_func, w_func_n;
  logic [0:DW-1]   r_data, w_data_n;
  logic [0:DW-1]   r_dout, w_dout_n;
  logic [2:0]      r_pia, w_pia_n;
  logic            r_done, w_done_n;
  logic            r_xfer, r_drv, r_strobe, r_ready, w_strobe_n;
  logic [0:DW-1]   r_dev_ebus, w_dev_ebus_n, w_rd_data;
  logic            w_sel, w_enter;
  logic            w_unused_ds;

  assign w_unused_ds = EBUS_DS[7];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_func     <= '0;
      r_data     <= '0;
      r_dout     <= '0;
      r_pia      <= '0;
      r_done     <= 1'b0;
      r_xfer     <= 1'b0;
      r_drv      <= 1'b0;
      r_strobe   <= 1'b0;
      r_ready    <= 1'b1;
      r_dev_ebus <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_n;
      r_func     <= w_func_n;
      r_data     <= w_data_n;
      r_dout     <= w_dout_n;
      r_pia      <= w_pia_n;
      r_done     <= w_done_n;
      r_xfer     <= (w_next == S_XFER);
      r_drv      <= (w_next != S_IDLE) && w_func_n[0];
      r_strobe   <= w_strobe_n;
      r_ready    <= ~w_done_n;
      r_dev_ebus <= w_dev_ebus_n;
    end
  end

  // Read word is a snapshot of device status/data taken when the cycle is selected
  always_comb begin
    w_rd_data = '0;
    if (ebusFunc == F_CONI)
      w_rd_data = {31'b0, (r_state != S_IDLE), r_done, r_pia};
    else if (ebusFunc == F_DATAI)
      w_rd_data = r_data;
  end

  // Next-state and register-update logic
  always_comb begin
    w_next       = r_state;
    w_cnt_n      = r_cnt;
    w_func_n     = r_func;
    w_sel        = 1'b0;
    w_enter      = 1'b0;
    w_data_n     = r_data;
    w_dout_n     = r_dout;
    w_pia_n      = r_pia;
    w_done_n     = r_done;
    w_strobe_n   = 1'b0;
    w_dev_ebus_n = r_dev_ebus;

    case (r_state)
      S_IDLE: begin
        if (ebusDemand && (EBUS_DS[0:6] == DEV_NUM) && !ebusFunc[0]) begin
          w_next   = S_WAIT;
          w_cnt_n  = CW'(XFER_DELAY - 1);
          w_func_n = ebusFunc;
          w_sel    = 1'b1;
        end
      end
      S_WAIT: begin
        if (!ebusDemand)
          w_next = S_IDLE;
        else if (r_cnt == '0) begin
          w_next  = S_XFER;
          w_enter = 1'b1;
        end else
          w_cnt_n = CW'(r_cnt - CW'(1));
      end
      S_XFER: begin
        if (!ebusDemand)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // Register side effects happen only on the single WAIT->XFER edge
    if (w_enter) begin
      case (r_func)
        F_CONO: begin
          if (EBUS[31]) w_done_n = 1'b0;
          if (EBUS[32]) w_done_n = 1'b1;
`ifdef EBUS_DEV_PI_EN
          w_pia_n = EBUS[33:35];
`endif
        end
        F_DATAI: w_done_n = 1'b0;
        F_DATAO: begin
          w_data_n   = EBUS;
          w_dout_n   = EBUS;
          w_strobe_n = 1'b1;
          w_done_n   = 1'b0;
        end
        default: ;
      endcase
    end

    // Device-side load; a DATAO landing the same edge takes priority
    if (devLoad && !w_done_n && !(w_enter && r_func == F_DATAO)) begin
      w_data_n = devData;
      w_done_n = 1'b1;
    end

    if (w_sel && ebusFunc[2])
      w_dev_ebus_n = w_rd_data;
    else if (w_sel || w_next == S_IDLE)
      w_dev_ebus_n = '0;
  end

  assign ebusXfer       = r_xfer;
  assign DEVdrivingEBUS = r_drv;
  assign DEV_EBUS       = r_dev_ebus;
  assign devReady       = r_ready;
  assign devDataOut     = r_dout;
  assign devDataStrobe  = r_strobe;

`ifdef EBUS_DEV_PI_EN
  logic [1:7] r_pi;

  // One-hot request on the assigned level, one cycle behind done/PIA
  always_ff @(posedge clk) begin
    if (reset)
      r_pi <= '0;
    else
      for (int n = 1; n <= 7; n++)
        r_pi[n] <= r_done && (r_pia == 3'(n));
  end

  assign piReq = r_pi;
`else
  assign piReq = '0;
`endif

endmodule

// File: tb/tb_ebus_dev.sv
// Directed self-checking bench for ebus_dev with default parameters
// (DEV_NUM=040, XFER_DELAY=2); expectations follow EBUS_DEV_PI_EN if defined.
module tb_ebus_dev;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] ebus;
  logic [7:0]  ds;
  logic [2:0]  func;
  logic        demand;
  logic        xfer, drv;
  logic [35:0] dev_ebus;
  logic        dev_load;
  logic [35:0] dev_data;
  logic        ready;
  logic [35:0] dout;
  logic        strobe;
  logic [6:0]  pi;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ebus_dev dut (
    .clk           (clk),
    .reset         (reset),
    .EBUS          (ebus),
    .EBUS_DS       (ds),
    .ebusFunc      (func),
    .ebusDemand    (demand),
    .ebusXfer      (xfer),
    .DEVdrivingEBUS(drv),
    .DEV_EBUS      (dev_ebus),
    .devLoad       (dev_load),
    .devData       (dev_data),
    .devReady      (ready),
    .devDataOut    (dout),
    .devDataStrobe (strobe),
    .piReq         (pi)
  );

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %o, expected %o", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] f, input logic [6:0] dn, input logic [35:0] d);
    func   = f;
    ds     = {dn, 1'b0};
    ebus   = d;
    demand = 1'b1;
  endtask

`ifdef EBUS_DEV_PI_EN
  localparam logic [35:0] CONI_EXP = 36'o000000000015;
  localparam logic [35:0] PI_EXP   = 36'b0000100;
`else
  localparam logic [35:0] CONI_EXP = 36'o000000000010;
  localparam logic [35:0] PI_EXP   = 36'b0;
`endif

  initial begin
    reset = 1'b1; ebus = '0; ds = '0; func = '0; demand = 1'b0;
    dev_load = 1'b0; dev_data = '0;
    step(); step();
    chk("rst_xfer",  36'(xfer),   36'd0);
    chk("rst_drv",   36'(drv),    36'd0);
    chk("rst_ebus",  dev_ebus,    36'd0);
    chk("rst_ready", 36'(ready),  36'd1);
    chk("rst_dout",  dout,        36'd0);
    chk("rst_strb",  36'(strobe), 36'd0);
    chk("rst_pi",    36'(pi),     36'd0);
    reset = 1'b0;
    step();

    // DATAO: xfer on cycle 3, one strobe
    start(3'd2, 7'o040, 36'o123456701234);
    step(); chk("do_c1_xfer", 36'(xfer), 36'd0);
    step(); chk("do_c2_xfer", 36'(xfer), 36'd0);
    step(); chk("do_c3_xfer", 36'(xfer), 36'd1);
    chk("do_dout",  dout, 36'o123456701234);
    chk("do_strb",  36'(strobe), 36'd1);
    chk("do_ready", 36'(ready), 36'd1);
    chk("do_drv",   36'(drv), 36'd0);
    step(); chk("do_hold_xfer", 36'(xfer), 36'd1);
    chk("do_strb_once", 36'(strobe), 36'd0);
    demand = 1'b0;
    step(); chk("do_end_xfer", 36'(xfer), 36'd0);

    // devLoad then DATAI
    dev_load = 1'b1; dev_data = 36'o777000111222;
    step(); dev_load = 1'b0;
    chk("ld_ready", 36'(ready), 36'd0);
    start(3'd3, 7'o040, 36'd0);
    step(); chk("di_c1_drv", 36'(drv), 36'd1);
    chk("di_c1_data", dev_ebus, 36'o777000111222);
    step(); chk("di_c2_drv", 36'(drv), 36'd1);
    step(); chk("di_c3_xfer", 36'(xfer), 36'd1);
    chk("di_c3_drv", 36'(drv), 36'd1);
    chk("di_c3_data", dev_ebus, 36'o777000111222);
    chk("di_ready", 36'(ready), 36'd1);
    demand = 1'b0;
    step(); chk("di_end_drv", 36'(drv), 36'd0);
    chk("di_end_ebus", dev_ebus, 36'd0);

    // CONO set done, PIA=5; then CONI
    start(3'd0, 7'o040, 36'o000000000015);
    step(); step(); step();
    chk("co_xfer", 36'(xfer), 36'd1);
    chk("co_ready", 36'(ready), 36'd0);
    demand = 1'b0;
    step(); step();
    chk("co_pi", 36'(pi), PI_EXP);
    start(3'd1, 7'o040, 36'd0);
    step(); chk("ci_drv", 36'(drv), 36'd1);
    chk("ci_data", dev_ebus, CONI_EXP);
    step(); step(); chk("ci_xfer", 36'(xfer), 36'd1);
    demand = 1'b0;
    step();

    // Wrong device, then reserved function: never answered
    start(3'd2, 7'o041, 36'o1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("nd_xfer", 36'(xfer), 36'd0);
      chk("nd_drv", 36'(drv), 36'd0);
    end
    start(3'd5, 7'o040, 36'o1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rf_xfer", 36'(xfer), 36'd0);
      chk("rf_drv", 36'(drv), 36'd0);
    end
    demand = 1'b0;
    step();

    // DATAO aborted in WAIT leaves data untouched
    start(3'd2, 7'o040, 36'o111111111111);
    step(); demand = 1'b0;
    step(); step();
    chk("ab_xfer", 36'(xfer), 36'd0);
    chk("ab_dout", dout, 36'o123456701234);
    chk("ab_strb", 36'(strobe), 36'd0);
    start(3'd3, 7'o040, 36'd0);
    step(); chk("ab_data", dev_ebus, 36'o777000111222);
    step(); step(); chk("ab_rd_xfer", 36'(xfer), 36'd1);

    // Reset asserted during XFER
    reset = 1'b1;
    step();
    chk("rx_xfer", 36'(xfer), 36'd0);
    chk("rx_drv", 36'(drv), 36'd0);
    chk("rx_ebus", dev_ebus, 36'd0);
    chk("rx_ready", 36'(ready), 36'd1);
    chk("rx_dout", dout, 36'd0);
    reset = 1'b0; demand = 1'b0;
    step();
    start(3'd1, 7'o040, 36'd0);
    step(); chk("rx_coni", dev_ebus, 36'd0);
    chk("rx_coni_drv", 36'(drv), 36'd1);
    demand = 1'b0;
    step();
    start(3'd3, 7'o040, 36'd0);
    step(); chk("rx_data", dev_ebus, 36'd0);
    step(); step();
    demand = 1'b0;
    step();

    // devLoad ignored while done; devLoad racing DATAI clear
    dev_load = 1'b1; dev_data = 36'o000000000777;
    step(); dev_data = 36'o000000000001;
    step(); dev_load = 1'b0;
    chk("rc_ready", 36'(ready), 36'd0);
    start(3'd3, 7'o040, 36'd0);
    step(); chk("rc_c1_data", dev_ebus, 36'o000000000777);
    step();
    dev_load = 1'b1; dev_data = 36'o555555555555;
    step(); dev_load = 1'b0;
    chk("rc_xfer", 36'(xfer), 36'd1);
    chk("rc_old", dev_ebus, 36'o000000000777);
    chk("rc_done", 36'(ready), 36'd0);
    step(); chk("rc_hold", dev_ebus, 36'o000000000777);
    demand = 1'b0;
    step();
    start(3'd3, 7'o040, 36'd0);
    step(); chk("rc_new", dev_ebus, 36'o555555555555);
    step(); step(); chk("rc_clr", 36'(ready), 36'd1);
    demand = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
